// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the ordered reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    STAGE    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } seq_state_t;

  // Counter only needs to reach the largest terminal value minus one.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned stage,
                                            input int unsigned timeout);
    int unsigned m;
    m = hold;
    if (stage > m) m = stage;
    if (timeout > m) m = timeout;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int unsigned dom_idx_width(input int unsigned num_dom);
    return (num_dom > 1) ? $clog2(num_dom) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the domains it manages.
interface reset_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM = 4
);

  localparam int IW = dom_idx_width(NUM_DOM);

  logic               soft_rst_req;
  logic [NUM_DOM-1:0] dom_ack;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               all_up;
  logic               fault;
  logic [IW-1:0]      fault_dom;
  logic [2:0]         seq_state;

  modport master (
    input  soft_rst_req,
    input  dom_ack,
    output dom_rst_n,
    output all_up,
    output fault,
    output fault_dom,
    output seq_state
  );

  modport slave (
    output soft_rst_req,
    output dom_ack,
    input  dom_rst_n,
    input  all_up,
    input  fault,
    input  fault_dom,
    input  seq_state
  );

endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold all domains, release one at a time after settle + ack,
// and drop everything back into reset on ack timeout, ack loss or software request.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM      = 4,
  parameter int HOLD_CYCLES  = 64,
  parameter int STAGE_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  reset_sequencer_if.master     bus
);

  localparam int IW = dom_idx_width(NUM_DOM);
  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_CYCLES, ACK_TIMEOUT);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

  seq_state_t         state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [NUM_DOM-1:0] rel, rel_n;
  logic               up, up_n;
  logic               flt, flt_n;
  logic [IW-1:0]      fdom, fdom_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      rel   <= '0;
      up    <= 1'b0;
      flt   <= 1'b0;
      fdom  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      rel   <= rel_n;
      up    <= up_n;
      flt   <= flt_n;
      fdom  <= fdom_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    rel_n   = rel;
    up_n    = up;
    flt_n   = flt;
    fdom_n  = fdom;

    if (bus.soft_rst_req) begin
      // fault_dom is left as a record of the last fault; only rst clears it.
      state_n = HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      rel_n   = '0;
      up_n    = 1'b0;
      flt_n   = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n  = STAGE;
            cnt_n    = '0;
            idx_n    = '0;
            rel_n[0] = 1'b1;
          end
        end
        STAGE: begin
          if (cnt == STAGE_LAST) begin
            state_n = WAIT_ACK;
            cnt_n   = '0;
          end
        end
        WAIT_ACK: begin
          if (bus.dom_ack[idx]) begin
            cnt_n = '0;
            if (32'(idx) < NUM_DOM - 1) begin
              idx_n               = idx + IW'(1);
              rel_n[idx + IW'(1)] = 1'b1;
              state_n             = STAGE;
            end else begin
              state_n = RUN;
              up_n    = 1'b1;
            end
          end else if (cnt == ACK_LAST) begin
            state_n = FAULT;
            cnt_n   = '0;
            rel_n   = '0;
            up_n    = 1'b0;
            flt_n   = 1'b1;
            fdom_n  = idx;
          end
        end
        RUN: begin
          cnt_n = '0;
          if (!(&bus.dom_ack)) begin
            state_n = FAULT;
            rel_n   = '0;
            up_n    = 1'b0;
            flt_n   = 1'b1;
            // Descending scan so the lowest dropped index wins.
            for (int unsigned i = NUM_DOM; i > 0; i--) begin
              if (!bus.dom_ack[i-1]) fdom_n = IW'(i - 1);
            end
          end
        end
        default: begin
          cnt_n = '0;
        end
      endcase
    end
  end

  assign bus.dom_rst_n = rel;
  assign bus.all_up    = up;
  assign bus.fault     = flt;
  assign bus.fault_dom = fdom;
  assign bus.seq_state = state;

endmodule
